// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the MIPS ALU and the ALU-control decoder.
//   alu_op_t       3-bit ALU operation code
//   OP_AND..OP_SLT operation encodings; codes 011, 100 and 101 are unused
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

endpackage : alu_pkg

// File: rtl/alu32_core.sv
// alu32_core: combinational datapath of the MIPS ALU.
//   a, b       operands
//   op         operation select (alu_op_t)
//   result     next Result value
//   carry_out  carry out of the shared adder (0 for logic/unused ops)
//   zero       1 when result is all zeros
module alu32_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    // One adder serves ADD, SUB and SLT: op[2] selects subtraction by
    // inverting B and injecting a carry-in of 1 (A + ~B + 1).
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             less;

    assign b_eff = op[2] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[2]};
    assign diff  = sum[WIDTH-1:0];

    // Signed less-than: the sign of A-B is wrong exactly when the
    // subtraction overflowed, which only happens for operands of opposite sign.
    assign ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign less = diff[WIDTH-1] ^ ovf;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        result    = '0;
        carry_out = 1'b0;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD, OP_SUB: begin
                result    = diff;
                carry_out = sum[WIDTH];
            end
            OP_SLT: begin
                result    = {{(WIDTH-1){1'b0}}, less};
                carry_out = sum[WIDTH];
            end
            default: begin
                result    = '0;
                carry_out = 1'b0;
            end
        endcase
    end

    // Zero is derived from the very value being registered so the two stay coherent.
    assign zero = (result == '0);

endmodule : alu32_core

// File: rtl/alu_32bit.sv
// alu_32bit: registered 32-bit MIPS ALU (one cycle latency).
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (Result=0, CarryOut=0, Zero=1)
//   Zero      registered; 1 when Result is all zeros
//   CarryOut  registered adder carry out
//   Result    registered operation result
//   A, B      operands
//   Op        operation select
module alu_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             Zero,
    output logic             CarryOut,
    output logic [WIDTH-1:0] Result,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  alu_op_t          Op
);

    logic [WIDTH-1:0] next_result;
    logic             next_carry;
    logic             next_zero;

    alu32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (A),
        .b         (B),
        .op        (Op),
        .result    (next_result),
        .carry_out (next_carry),
        .zero      (next_zero)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous
    // so the outputs take their reset values the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result   <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b1;
        end else begin
            Result   <= next_result;
            CarryOut <= next_carry;
            Zero     <= next_zero;
        end
    end

endmodule : alu_32bit

// File: tb/tb_alu_32bit.sv
// tb_alu_32bit: self-checking bench for alu_32bit.
//   Directed vector table, hold/reset sequences, and a back-to-back sweep
//   over all op codes compared against an independent reference model.
module tb_alu_32bit;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        Zero;
    logic        CarryOut;
    logic [31:0] Result;
    logic [31:0] A;
    logic [31:0] B;
    alu_op_t     Op;

    int n_checks = 0;
    int n_pass   = 0;

    alu_32bit #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Zero     (Zero),
        .CarryOut (CarryOut),
        .Result   (Result),
        .A        (A),
        .B        (B),
        .Op       (Op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        z;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    // Reference model written independently of the RTL: SLT uses the
    // language's signed compare, carry of a subtraction is "A >= B unsigned".
    function automatic exp_t ref_model(alu_op_t op, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        logic [32:0] wide;
        e = '0;
        case (op)
            3'b000: e.r = a & b;
            3'b001: e.r = a | b;
            3'b010: begin
                wide = {1'b0, a} + {1'b0, b};
                e.r  = wide[31:0];
                e.c  = wide[32];
            end
            3'b110: begin
                e.r = a - b;
                e.c = (a >= b);
            end
            3'b111: begin
                e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                e.c = (a >= b);
            end
            default: e = '0;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] exp_r,
                         input logic exp_c, input logic exp_z);
        n_checks++;
        if (Result === exp_r && CarryOut === exp_c && Zero === exp_z) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got Result=%h CarryOut=%b Zero=%b, want Result=%h CarryOut=%b Zero=%b",
                     name, Result, CarryOut, Zero, exp_r, exp_c, exp_z);
        end
    endtask

    // Drive at the falling edge, let the rising edge capture, sample 1ns later.
    task automatic apply(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Op = op;
        A  = a;
        B  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;

        vecs[0]  = '{OP_AND, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000000, 1'b0, 1'b1};
        vecs[1]  = '{OP_OR,  32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 1'b0, 1'b0};
        vecs[2]  = '{OP_ADD, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h4b4b4b4b, 1'b1, 1'b0};
        vecs[4]  = '{OP_SUB, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'h00000000, 1'b1, 1'b1};
        vecs[5]  = '{OP_SLT, 32'h5a5a5a5a, 32'ha5a5a5a5, 32'h00000000, 1'b0, 1'b1};
        vecs[6]  = '{OP_SLT, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000001, 1'b1, 1'b0};
        vecs[7]  = '{OP_ADD, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{3'b100, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{3'b101, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000000, 1'b0, 1'b1};
        vecs[11] = '{OP_SLT, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0};
        vecs[12] = '{OP_SLT, 32'hffffffff, 32'h00000000, 32'h00000001, 1'b1, 1'b0};
        vecs[13] = '{OP_ADD, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0};

        // Run a couple of cycles out of reset so the registers hold
        // non-reset values, then assert reset between edges.
        rst_n = 1'b1;
        Op    = OP_OR;
        A     = 32'ha5a5a5a5;
        B     = 32'h5a5a5a5a;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_or", 32'hffffffff, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        Op    = OP_ADD;
        A     = 32'hffffffff;
        B     = 32'h00000001;
        #1;
        check("reset_async", 32'h00000000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 32'h00000000, 1'b0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        apply(OP_AND, 32'h0, 32'h0);
        check("first_after_reset_and0", 32'h00000000, 1'b0, 1'b1);

        // Latency and hold: the next Result appears one edge after inputs,
        // and input changes between edges do not disturb the outputs.
        apply(OP_OR, 32'ha5a5a5a5, 32'h5a5a5a5a);
        check("latency_or", 32'hffffffff, 1'b0, 1'b0);
        @(negedge clk);
        Op = OP_AND;
        A  = 32'h0;
        #2;
        check("hold_between_edges", 32'hffffffff, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec[%0d] op=%b", i, vecs[i].op), vecs[i].r, vecs[i].c, vecs[i].z);
        end

        // Back-to-back sweep: op changes every cycle over all eight codes.
        for (int i = 0; i < 40; i++) begin
            alu_op_t     op;
            logic [31:0] a;
            logic [31:0] b;
            op = alu_op_t'(i % 8);
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            apply(op, a, b);
            e = ref_model(op, a, b);
            check($sformatf("sweep[%0d] op=%b", i, op), e.r, e.c, e.z);
            if (i == 20) begin
                #3;
                rst_n = 1'b0;
                #1;
                check("reset_mid_stream", 32'h00000000, 1'b0, 1'b1);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_32bit

// File: doc/alu_32bit.md
# alu_32bit

Registered 32-bit integer ALU for the single-cycle MIPS datapath, driven by the 3-bit ALU control code from the ALU-control decoder. Performs AND, OR, ADD, SUB and signed set-on-less-than on operands A and B, and reports Result, a carry-out flag and a zero flag (used for BEQ). A combinational core computes the operation and its flags; all three outputs are captured in registers on the rising clock edge.

## Interface
Parameters:
- WIDTH, 32, operand and result width. Only 32 is required to be supported.

Ports, in positional order:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Zero  output  1  registered; 1 when the registered Result is all zeros.
- CarryOut  output  1  registered carry out of bit 31 of the adder.
- Result  output  32  registered operation result.
- A  input  32  operand A.
- B  input  32  operand B.
- Op  input  3  operation select.

## Operation
- Op 000, AND: Result = A & B; CarryOut = 0.
- Op 001, OR: Result = A | B; CarryOut = 0.
- Op 010, ADD: {CarryOut, Result} = A + B, computed 33 bits wide and modulo 2^32.
- Op 110, SUB: Result = A + ~B + 1. CarryOut is the carry out of that sum, so 1 means no unsigned borrow (A ≥ B unsigned).
- Op 111, SLT: signed compare.
  - Compute D = A − B and overflow V = (A[31] ≠ B[31]) & (D[31] ≠ A[31]).
  - less = D[31] ^ V.
  - Result = {31'b0, less}; CarryOut = carry out of A + ~B + 1.
- Op 011, 100, 101 (unused): Result = 0, CarryOut = 0.
- Zero = (next Result == 0). It is computed from the same value being registered, so Zero and Result are always coherent.
- No overflow or exception output. Signed overflow is used internally for SLT only.

## Timing
- Latency is 1 cycle. The outputs reflect A, B and Op sampled at the previous rising edge of clk.
- No handshake. A new operation is accepted every cycle, and outputs hold until the next edge.
- Reset: while rst_n is low, Result = 0, CarryOut = 0 and Zero = 1, applied immediately (asynchronously).
- Reset released: the first capture happens at the first rising edge with rst_n high.
- Reset asserted mid-stream: the in-flight result is discarded and the outputs go to their reset values at once.
- Changing Op or an operand between edges has no effect on the outputs until the next edge.

## Structure
- Shared package alu_pkg holds:
  - the 3-bit op-code localparams: OP_AND=000, OP_OR=001, OP_ADD=010, OP_SUB=110, OP_SLT=111;
  - a typedef for the op field.
  The ALU-control decoder uses the same package.
- One sub-module, alu32_core. It is purely combinational and produces the next Result, CarryOut and Zero.
- The core uses a single shared 33-bit adder. Its B input is inverted and carry-in set to 1 when Op[2] = 1.
- Top level alu_32bit contains only the output registers with asynchronous reset around alu32_core.

## Test plan
- Reset: hold rst_n low with arbitrary inputs -> Result=0, CarryOut=0, Zero=1 immediately; release, then one edge with AND 0/0 -> Result 0, Zero 1.
- A=a5a5a5a5, B=5a5a5a5a:
  - Op 000 -> Result 00000000, CarryOut 0, Zero 1.
  - Op 001 -> Result ffffffff, Zero 0.
  - Op 010 -> Result ffffffff, CarryOut 0, Zero 0.
  - Each result appears one edge after the inputs are applied.
- SUB with A=a5a5a5a5, B=5a5a5a5a -> Result 4b4b4b4b, CarryOut 1, Zero 0. SUB with A=B=a5a5a5a5 -> Result 0, CarryOut 1, Zero 1.
- SLT with A=5a5a5a5a, B=a5a5a5a5 (positive vs negative, overflowing difference) -> Result 0, CarryOut 0, Zero 1. Swap the operands -> Result 00000001, Zero 0.
- ADD ffffffff + 00000001 -> Result 0, CarryOut 1, Zero 1. Op 100 -> Result 0, CarryOut 0, Zero 1.
- Back-to-back Op change every cycle over all codes with random operands -> each output cycle matches the reference model of the previous cycle's inputs. Assert rst_n mid-sequence -> outputs go to reset values asynchronously.
